hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Parametrised hazard detection and stall controller for the 5-stage pipeline. It sits beside the D/E pipeline registers and generates stall and bubble controls for three cases: load-use hazards, multi-cycle multiply occupancy of the E stage, and taken-branch flushes. It generalises the single-cycle multiply stall to a counted MUL_LAT-cycle stall, and it excludes register zero from load-use detection.

Parameters:
ADDR_W, 5, register address width
OPC_W, 6, opcode width
MUL_OPC, `MULL, opcode that starts a multi-cycle multiply
MUL_LAT, 4, total stall cycles per multiply (legal range 1..15)
CNT_W, 4, multiply counter width (must satisfy 2^CNT_W > MUL_LAT)
STALL_CNT_W, 16, width of the optional stall statistics counter

Ports:
clock  input  1  pipeline clock
nReset  input  1  reset, asynchronous, active-low
MemReadE  input  1  E-stage instruction is a load
OpCodeE  input  OPC_W  E-stage opcode
RtAddrE  input  ADDR_W  E-stage load destination
RsAddrD  input  ADDR_W  D-stage source register rs
RtAddrD  input  ADDR_W  D-stage source register rt
RtUsedD  input  1  D-stage instruction actually reads rt
FlushE  input  1  taken branch/jump; squash E stage this cycle
nStall  output  1  0 = hold PC, F/D and D/E registers
BubbleE  output  1  1 = load a NOP into D/E on the next edge
MulBusy  output  1  multiply in progress
StallCount  output  STALL_CNT_W  stall-cycle count (feature-dependent)

Behaviour:
- Reset (nReset low, asynchronous): state=IDLE, counter=0. Outputs: nStall=1, BubbleE=0, MulBusy=0, StallCount=0.
- Load-use term LU = MemReadE && RtAddrE!=0 && (RtAddrE==RsAddrD || (RtUsedD && RtAddrE==RtAddrD)). LU is combinational, with zero latency.
- LU=1 gives nStall=0 and BubbleE=1 for exactly that cycle. The load advances while the dependent instruction is held in D.
- Multiply FSM, states IDLE, MUL_BUSY, MUL_DONE:
  - IDLE with OpCodeE==MUL_OPC and !FlushE: nStall=0 combinationally in the same cycle. If MUL_LAT==1, next state is MUL_DONE. Otherwise next state is MUL_BUSY, with cnt loaded to MUL_LAT-1.
  - MUL_BUSY: nStall=0 and MulBusy=1. cnt decrements each cycle. When cnt==1, next state is MUL_DONE.
  - MUL_DONE: OpCodeE is ignored (the same multiply is still in E), nStall=1, and the multiply advances. Next state is IDLE unconditionally.
  - Total stall = exactly MUL_LAT cycles per multiply. Back-to-back multiplies: the second is recognised in the IDLE cycle after MUL_DONE.
- MulBusy=1 in the IDLE cycle where the multiply is recognised, and in MUL_BUSY.
- nStall = !(LU || multiply stall term). BubbleE = LU && !multiply stall term. LU cannot coexist with a multiply in E, but the multiply term wins if both assert.
- FlushE=1 has priority over everything:
  - FSM goes to IDLE and cnt is cleared on the next edge.
  - nStall=1 and BubbleE=0 in the flush cycle.
  - A multiply in E during a flush is discarded and never stalls.
- Register zero as a load destination never causes a stall.

Optional Feature:
HDU_STALL_CNT_EN
- Defined: StallCount increments by 1 on every clock edge where nStall==0. It saturates at all-ones and clears only on reset.
- Undefined: StallCount is tied to 0 and no counter flops are built. The port is present in both builds.

Test Plan:
- Reset release → nStall=1, BubbleE=0, MulBusy=0, StallCount=0.
- MemReadE=1, RtAddrE=5, RsAddrD=5 → nStall=0, BubbleE=1 for 1 cycle.
- Repeat with RtAddrE=0, RsAddrD=0 → nStall=1.
- MemReadE=1, RtAddrE=7, RtAddrD=7, RtUsedD=0 → no stall. Same with RtUsedD=1 → 1-cycle stall.
- OpCodeE=MUL_OPC held, MUL_LAT=4 → nStall=0 for exactly 4 cycles, then 1 for one cycle (MUL_DONE), with no re-trigger. Repeat with MUL_LAT=1 → 1-cycle stall.
- Multiply started, FlushE=1 on its 2nd stall cycle → nStall=1 in that cycle, FSM in IDLE on the next edge. Also: nReset pulsed low mid-multiply → all outputs return to reset values immediately.
- HDU_STALL_CNT_EN defined, one load-use plus one multiply (MUL_LAT=4) → StallCount=5. Force near-max → saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use, multi-cycle multiply and flush stall/bubble control
// Optional stall statistics counter enabled by defining HDU_STALL_CNT_EN.
`ifndef MULL
`define MULL 6'h18
`endif

module hazard_ctrl_unit #(
    parameter int ADDR_W = 5,
    parameter int OPC_W = 6,
    parameter logic [OPC_W-1:0] MUL_OPC = `MULL,
    parameter int MUL_LAT = 4,
    parameter int CNT_W = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   nReset,
    input  logic                   MemReadE,
    input  logic [OPC_W-1:0]       OpCodeE,
    input  logic [ADDR_W-1:0]      RtAddrE,
    input  logic [ADDR_W-1:0]      RsAddrD,
    input  logic [ADDR_W-1:0]      RtAddrD,
    input  logic                   RtUsedD,
    input  logic                   FlushE,
    output logic                   nStall,
    output logic                   BubbleE,
    output logic                   MulBusy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lu;
    logic             w_mul_stall;
    logic             w_nstall;

    // Register zero is never a real load destination, so it cannot create a dependency
    assign w_lu = MemReadE && (RtAddrE != '0) &&
                  ((RtAddrE == RsAddrD) || (RtUsedD && (RtAddrE == RtAddrD)));

    // A flush squashes the E-stage multiply, so it never stalls in that cycle
    assign w_mul_stall = !FlushE && (((r_state == IDLE) && (OpCodeE == MUL_OPC)) ||
                                     (r_state == MUL_BUSY));

    assign w_nstall = FlushE || !(w_lu || w_mul_stall);
    assign nStall   = w_nstall;
    assign BubbleE  = !FlushE && w_lu && !w_mul_stall;
    assign MulBusy  = w_mul_stall;

    // Multiply occupancy FSM: the recognising IDLE cycle plus MUL_LAT-1 busy cycles
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (FlushE) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (OpCodeE == MUL_OPC) begin
                    r_state <= (MUL_LAT == 1) ? MUL_DONE : MUL_BUSY;
                    r_cnt   <= CNT_W'(MUL_LAT - 1);
                end
                MUL_BUSY: begin
                    r_cnt   <= r_cnt - 1'b1;
                    r_state <= (r_cnt == CNT_W'(1)) ? MUL_DONE : MUL_BUSY;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef HDU_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Saturating count of clock edges on which the pipeline was held
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset)
            r_stall_cnt <= '0;
        else if (!w_nstall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign StallCount = r_stall_cnt;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed checks of two hazard_ctrl_unit builds (MUL_LAT 4 and 1)
module tb_hazard_ctrl_unit;

    localparam logic [5:0] MUL = 6'h2a;

    logic        clock = 1'b0;
    logic        nReset;
    logic        MemReadE;
    logic [5:0]  OpCodeE;
    logic [4:0]  RtAddrE, RsAddrD, RtAddrD;
    logic        RtUsedD, FlushE;
    logic        a_nstall, a_bubble, a_busy;
    logic [15:0] a_cnt;
    logic        b_nstall, b_bubble, b_busy;
    logic [2:0]  b_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    hazard_ctrl_unit #(.MUL_OPC(MUL), .MUL_LAT(4), .CNT_W(4), .STALL_CNT_W(16)) u_a (
        .clock(clock), .nReset(nReset), .MemReadE(MemReadE), .OpCodeE(OpCodeE),
        .RtAddrE(RtAddrE), .RsAddrD(RsAddrD), .RtAddrD(RtAddrD), .RtUsedD(RtUsedD),
        .FlushE(FlushE), .nStall(a_nstall), .BubbleE(a_bubble), .MulBusy(a_busy),
        .StallCount(a_cnt));

    hazard_ctrl_unit #(.MUL_OPC(MUL), .MUL_LAT(1), .CNT_W(2), .STALL_CNT_W(3)) u_b (
        .clock(clock), .nReset(nReset), .MemReadE(MemReadE), .OpCodeE(OpCodeE),
        .RtAddrE(RtAddrE), .RsAddrD(RsAddrD), .RtAddrD(RtAddrD), .RtUsedD(RtUsedD),
        .FlushE(FlushE), .nStall(b_nstall), .BubbleE(b_bubble), .MulBusy(b_busy),
        .StallCount(b_cnt));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] act, input logic [31:0] exp_en);
`ifdef HDU_STALL_CNT_EN
        chk(tag, act, exp_en);
`else
        chk(tag, act, 32'd0);
`endif
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        MemReadE = 0; OpCodeE = 6'h00; RtAddrE = 0; RsAddrD = 0; RtAddrD = 0;
        RtUsedD = 0; FlushE = 0;
    endtask

    initial begin
        nReset = 0;
        idle_inputs();
        #2;
        chk("rst_a_nstall", a_nstall, 1);
        chk("rst_a_bubble", a_bubble, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_b_nstall", b_nstall, 1);
        cyc();
        nReset = 1;
        cyc();
        // load-use through rs
        MemReadE = 1; RtAddrE = 5; RsAddrD = 5;
        #1;
        chk("lu_rs_a_nstall", a_nstall, 0);
        chk("lu_rs_a_bubble", a_bubble, 1);
        chk("lu_rs_b_bubble", b_bubble, 1);
        cyc();
        MemReadE = 0;
        #1;
        chk("lu_rs_after", a_nstall, 1);
        chk_cnt("cnt_lu1", a_cnt, 1);
        // register zero destination
        MemReadE = 1; RtAddrE = 0; RsAddrD = 0;
        #1;
        chk("lu_r0_nstall", a_nstall, 1);
        chk("lu_r0_bubble", a_bubble, 0);
        cyc();
        // load-use through rt, gated by RtUsedD
        RtAddrE = 7; RtAddrD = 7; RsAddrD = 3; RtUsedD = 0;
        #1;
        chk("lu_rt_unused", a_nstall, 1);
        RtUsedD = 1;
        #1;
        chk("lu_rt_used_nstall", a_nstall, 0);
        chk("lu_rt_used_bubble", a_bubble, 1);
        cyc();
        idle_inputs();
        #1;
        chk_cnt("cnt_lu2", a_cnt, 2);
        chk_cnt("cnt_lu2_b", b_cnt, 2);
        // multiply held: a stalls 4 then MUL_DONE; b alternates stall/done
        OpCodeE = MUL;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("mul_a_nstall_%0d", i), a_nstall, (i == 4));
            chk($sformatf("mul_a_busy_%0d", i), a_busy, (i != 4));
            chk($sformatf("mul_a_bubble_%0d", i), a_bubble, 0);
            chk($sformatf("mul_b_nstall_%0d", i), b_nstall, (i % 2 == 1));
            cyc();
        end
        OpCodeE = 6'h00;
        #1;
        chk("mul_end_a", a_nstall, 1);
        chk("mul_end_b_done", b_nstall, 1);
        chk("mul_end_b_busy", b_busy, 0);
        chk_cnt("cnt_mul_a", a_cnt, 6);
        chk_cnt("cnt_mul_b", b_cnt, 5);
        cyc();
        // flush on the second stall cycle of a multiply
        OpCodeE = MUL;
        #1;
        chk("fl_start_a", a_nstall, 0);
        cyc();
        FlushE = 1; MemReadE = 1; RtAddrE = 5; RsAddrD = 5;
        #1;
        chk("fl_a_nstall", a_nstall, 1);
        chk("fl_a_bubble", a_bubble, 0);
        chk("fl_a_busy", a_busy, 0);
        chk("fl_b_nstall", b_nstall, 1);
        cyc();
        idle_inputs();
        #1;
        chk("fl_after_a_nstall", a_nstall, 1);
        chk("fl_after_a_busy", a_busy, 0);
        // multiply arriving together with a flush is discarded
        FlushE = 1; OpCodeE = MUL;
        #1;
        chk("fl_mul_idle_a", a_nstall, 1);
        chk("fl_mul_idle_busy", a_busy, 0);
        cyc();
        idle_inputs();
        #1;
        chk("fl_mul_gone_a", a_nstall, 1);
        chk("fl_mul_gone_b", b_nstall, 1);
        chk_cnt("cnt_fl_a", a_cnt, 7);
        chk_cnt("cnt_fl_b", b_cnt, 6);
        // three load-use cycles: b's 3-bit counter saturates at 7
        MemReadE = 1; RtAddrE = 9; RsAddrD = 9;
        cyc(); cyc(); cyc();
        idle_inputs();
        #1;
        chk_cnt("cnt_sat_a", a_cnt, 10);
        chk_cnt("cnt_sat_b", b_cnt, 7);
        // asynchronous reset in the middle of a multiply
        OpCodeE = MUL;
        cyc();
        OpCodeE = 6'h00;
        #1;
        chk("mid_a_busy", a_busy, 1);
        chk("mid_a_nstall", a_nstall, 0);
        #1;
        nReset = 0;
        #1;
        chk("arst_a_nstall", a_nstall, 1);
        chk("arst_a_busy", a_busy, 0);
        chk("arst_a_cnt", a_cnt, 0);
        chk("arst_b_cnt", b_cnt, 0);
        cyc();
        nReset = 1;
        cyc();
        #1;
        chk("post_rst_a_nstall", a_nstall, 1);
        chk("post_rst_a_busy", a_busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
